// File: rtl/sysid_arbiter_pkg.sv
// Shared types and constants for the system-ID arbiter.
package sysid_arbiter_pkg;

  typedef enum logic [1:0] {
    ChkId,
    ChkTs,
    ChkEnd,
    Arb
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam int unsigned MISMATCH_W = 8;

endpackage

// File: rtl/sysid_rr_arb2.sv
// Two-way round-robin arbiter; the master not granted last wins a tie.
module sysid_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = master 1 held the most recent grant
  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (|gnt) last_grant_d = gnt[1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sysid_arbiter.sv
// Shares the read-only sysid slave between two masters after checking the
// ID and timestamp words against their expected values.
module sysid_arbiter
  import sysid_arbiter_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'h5C00_A374
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_read,
  input  logic                  m0_address,
  output logic                  m0_waitrequest,
  output logic [31:0]           m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic                  m1_read,
  input  logic                  m1_address,
  output logic                  m1_waitrequest,
  output logic [31:0]           m1_readdata,
  output logic                  m1_readdatavalid,
  output logic                  sid_address,
  input  logic [31:0]           sid_readdata,
  input  logic                  recheck,
  output logic                  boot_done,
  output logic                  boot_ok,
  output logic [MISMATCH_W-1:0] mismatch_cnt
);

  state_e                state_q, state_d;
  logic [31:0]           id_cap_q, ts_cap_q;
  logic                  boot_done_q, boot_ok_q;
  logic [MISMATCH_W-1:0] mismatch_cnt_q;
  logic                  rdv0_q, rdv1_q;
  logic [31:0]           rd0_q, rd1_q;
  logic [1:0]            gnt;
  logic                  in_arb, advance, check_pass;

  assign in_arb     = (state_q == Arb);
  // No grant in the recheck cycle or while reset discards the response path
  assign advance    = in_arb && !recheck && !reset;
  assign check_pass = (id_cap_q == EXPECTED_ID) && (ts_cap_q == EXPECTED_TS);

  sysid_rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({m1_read, m0_read}),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    sid_address = ADDR_ID;
    unique case (state_q)
      ChkId: begin
        sid_address = ADDR_ID;
        state_d     = ChkTs;
      end
      ChkTs: begin
        sid_address = ADDR_TS;
        state_d     = ChkEnd;
      end
      ChkEnd: state_d = Arb;
      Arb: begin
        sid_address = gnt[1] ? m1_address : m0_address;
        if (recheck) state_d = ChkId;
      end
      default: state_d = ChkId;
    endcase
  end

  assign m0_waitrequest = !in_arb || reset || (m0_read && !gnt[0]);
  assign m1_waitrequest = !in_arb || reset || (m1_read && !gnt[1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ChkId;
      id_cap_q       <= '0;
      ts_cap_q       <= '0;
      boot_done_q    <= 1'b0;
      boot_ok_q      <= 1'b0;
      mismatch_cnt_q <= '0;
      rdv0_q         <= 1'b0;
      rdv1_q         <= 1'b0;
      rd0_q          <= '0;
      rd1_q          <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ChkId) id_cap_q <= sid_readdata;
      if (state_q == ChkTs) ts_cap_q <= sid_readdata;
      if (state_q == ChkEnd) begin
        boot_done_q <= 1'b1;
        boot_ok_q   <= check_pass;
        if (!check_pass && (mismatch_cnt_q != '1)) mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
      end
      if (in_arb && recheck) begin
        boot_done_q <= 1'b0;
        boot_ok_q   <= 1'b0;
      end
      rdv0_q <= gnt[0];
      rdv1_q <= gnt[1];
      if (gnt[0]) rd0_q <= sid_readdata;
      if (gnt[1]) rd1_q <= sid_readdata;
    end
  end

  assign boot_done        = boot_done_q;
  assign boot_ok          = boot_ok_q;
  assign mismatch_cnt     = mismatch_cnt_q;
  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;
  assign m0_readdata      = rd0_q;
  assign m1_readdata      = rd1_q;

endmodule

// File: tb/tb_sysid_arbiter.sv
// Directed bench for sysid_arbiter with a sysid slave model and a per-master
// response scoreboard.
module tb_sysid_arbiter;

  localparam logic [31:0] GOOD_TS = 32'h5C00_A374;
  localparam logic [31:0] BAD_TS  = 32'h5C00_A375;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_read, m0_address, m0_waitrequest, m0_readdatavalid;
  logic        m1_read, m1_address, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        sid_address;
  logic [31:0] sid_readdata;
  logic        recheck, boot_done, boot_ok;
  logic [7:0]  mismatch_cnt;

  logic [31:0] id_val = 32'h0;
  logic [31:0] ts_val = GOOD_TS;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clock = ~clock;

  // Combinational sysid slave
  assign sid_readdata = sid_address ? ts_val : id_val;

  sysid_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .m0_read          (m0_read),
    .m0_address       (m0_address),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_read          (m1_read),
    .m1_address       (m1_address),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .sid_address      (sid_address),
    .sid_readdata     (sid_readdata),
    .recheck          (recheck),
    .boot_done        (boot_done),
    .boot_ok          (boot_ok),
    .mismatch_cnt     (mismatch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slave_model(input logic addr);
    return addr ? ts_val : id_val;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Scoreboard: an accept this cycle must produce exactly one valid next cycle
  always @(negedge clock) begin
    if (mon_en) begin
      if (q0.size() > 0) begin
        chk("m0_rdv", m0_readdatavalid, 1'b1);
        chk("m0_data", m0_readdata, q0.pop_front());
      end else begin
        chk("m0_rdv_idle", m0_readdatavalid, 1'b0);
      end
      if (q1.size() > 0) begin
        chk("m1_rdv", m1_readdatavalid, 1'b1);
        chk("m1_data", m1_readdata, q1.pop_front());
      end else begin
        chk("m1_rdv_idle", m1_readdatavalid, 1'b0);
      end
      if (!reset && m0_read && !m0_waitrequest) q0.push_back(slave_model(m0_address));
      if (!reset && m1_read && !m1_waitrequest) q1.push_back(slave_model(m1_address));
    end
  end

  initial begin
    reset = 1'b1; recheck = 1'b0;
    m0_read = 1'b1; m0_address = 1'b1;
    m1_read = 1'b1; m1_address = 1'b1;

    // Reset values, with both masters already requesting
    cyc();
    mon_en = 1'b1;
    sample();
    chk("rst_boot_done", boot_done, 1'b0);
    chk("rst_boot_ok", boot_ok, 1'b0);
    chk("rst_cnt", mismatch_cnt, 8'h00);
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_m1_wait", m1_waitrequest, 1'b1);
    chk("rst_m0_data", m0_readdata, 32'h0);
    cyc();
    reset = 1'b0;

    // Three check cycles: masters stalled, boot not yet done
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("boot_m0_wait", m0_waitrequest, 1'b1);
      chk("boot_m1_wait", m1_waitrequest, 1'b1);
      chk("boot_done_low", boot_done, 1'b0);
      cyc();
    end

    // Both reading address 1: strict alternation starting with m0
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i == 0) begin
        chk("boot_done", boot_done, 1'b1);
        chk("boot_ok", boot_ok, 1'b1);
        chk("boot_cnt", mismatch_cnt, 8'h00);
      end
      chk("alt_m0_wait", m0_waitrequest, 32'(i % 2));
      chk("alt_m1_wait", m1_waitrequest, 32'((i + 1) % 2));
      cyc();
    end

    // m1 alone, back-to-back reads of address 0
    m0_read = 1'b0; m1_address = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("solo_m1_wait", m1_waitrequest, 1'b0);
      chk("solo_m0_wait", m0_waitrequest, 1'b0);
      if (i == 0) chk("m0_data_hold", m0_readdata, GOOD_TS);
      cyc();
    end
    m1_read = 1'b0;
    cyc();

    // Recheck the cycle after an m0 accept
    m0_read = 1'b1; m0_address = 1'b0;
    sample();
    chk("rc_m0_accept", m0_waitrequest, 1'b0);
    cyc();
    m0_read = 1'b0; recheck = 1'b1; m1_read = 1'b1; m1_address = 1'b1;
    sample();
    chk("rc_no_grant", m1_waitrequest, 1'b1);
    chk("rc_m0_rdv", m0_readdatavalid, 1'b1);
    chk("rc_done_still", boot_done, 1'b1);
    cyc();
    recheck = 1'b0; m0_read = 1'b1; m0_address = 1'b1;
    for (int i = 0; i < 3; i++) begin
      recheck = (i == 1);  // pulse outside arbitration must be ignored
      sample();
      chk("rc_done_low", boot_done, 1'b0);
      chk("rc_ok_low", boot_ok, 1'b0);
      chk("rc_m0_wait", m0_waitrequest, 1'b1);
      chk("rc_m1_wait", m1_waitrequest, 1'b1);
      cyc();
    end
    recheck = 1'b0;
    sample();
    chk("rc_done_again", boot_done, 1'b1);
    chk("rc_m1_wins", m1_waitrequest, 1'b0);
    chk("rc_m0_waits", m0_waitrequest, 1'b1);
    cyc();
    m1_read = 1'b0;
    sample();
    chk("rc_m0_next", m0_waitrequest, 1'b0);
    cyc();
    m0_read = 1'b0;
    cyc();

    // Bad timestamp: failed check, then saturate the counter
    ts_val = BAD_TS;
    recheck = 1'b1;
    cyc();
    recheck = 1'b0;
    cyc(); cyc(); cyc();
    sample();
    chk("bad_done", boot_done, 1'b1);
    chk("bad_ok", boot_ok, 1'b0);
    chk("bad_cnt1", mismatch_cnt, 8'h01);
    for (int i = 0; i < 300; i++) begin
      recheck = 1'b1;
      cyc();
      recheck = 1'b0;
      cyc(); cyc(); cyc();
      sample();
      if (i == 0) chk("bad_cnt2", mismatch_cnt, 8'h02);
    end
    chk("sat_cnt", mismatch_cnt, 8'hFF);
    chk("sat_ok", boot_ok, 1'b0);

    // Reset while m0 requests: no response, reset values, boot reruns
    ts_val = GOOD_TS;
    cyc();
    reset = 1'b1; m0_read = 1'b1; m0_address = 1'b1;
    sample();
    chk("mid_m0_wait", m0_waitrequest, 1'b1);
    cyc();
    reset = 1'b0; m0_read = 1'b0;
    sample();
    chk("mid_rdv", m0_readdatavalid, 1'b0);
    chk("mid_done", boot_done, 1'b0);
    chk("mid_ok", boot_ok, 1'b0);
    chk("mid_cnt", mismatch_cnt, 8'h00);
    chk("mid_m0_data", m0_readdata, 32'h0);
    chk("mid_m1_data", m1_readdata, 32'h0);
    chk("mid_m0_wait_rst", m0_waitrequest, 1'b1);
    chk("mid_m1_wait_rst", m1_waitrequest, 1'b1);
    cyc(); cyc(); cyc();
    sample();
    chk("rerun_done", boot_done, 1'b1);
    chk("rerun_ok", boot_ok, 1'b1);
    chk("rerun_cnt", mismatch_cnt, 8'h00);
    cyc();
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sysid_arbiter.md
# sysid_arbiter

Read-only Avalon-MM front end that shares the single system-ID slave (32-bit word at address 0 = system ID, address 1 = build timestamp, zero-latency combinational readdata) between two masters: the Nios II data master and the JTAG debug master. After every reset, and on request, an internal sequencer reads both words and checks them against compile-time expected values, so software and the debug host can trust the ID before use. The block sits between the interconnect and the sysid slave; it is the only driver of the slave's address.

## Interface
- EXPECTED_ID, 32'h0000_0000, required system-ID word (address 0)
- EXPECTED_TS, 32'h5C00_A374, required timestamp word (address 1)

- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_read  in  1  master 0 read request
- m0_address  in  1  master 0 word address
- m0_waitrequest  out  1  high = master 0 request not accepted this cycle
- m0_readdata  out  32  master 0 read data
- m0_readdatavalid  out  1  master 0 data valid
- m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: same as master 0, for master 1
- sid_address  out  1  address to sysid slave
- sid_readdata  in  32  sysid slave data, combinational on sid_address
- recheck  in  1  single-cycle pulse: re-run the ID check
- boot_done  out  1  check sequence completed
- boot_ok  out  1  both words matched on last completed check
- mismatch_cnt  out  8  saturating count of failed checks since reset

## Operation
- FSM states: CHK_ID, CHK_TS, CHK_END, ARB. Reset enters CHK_ID.
- CHK_ID: sid_address=0, latch sid_readdata as id_cap. -> CHK_TS.
- CHK_TS: sid_address=1, latch ts_cap. -> CHK_END.
- CHK_END: boot_done<=1; boot_ok<=(id_cap==EXPECTED_ID)&&(ts_cap==EXPECTED_TS); on mismatch mismatch_cnt+=1, saturating at 8'hFF. -> ARB.
- ARB: round-robin between m0/m1. Grant is combinational from m*_read and last_grant. Only one requester -> grant it. Both -> grant the master not in last_grant. The granted master sees waitrequest=0 (accepted); sid_address = its address; sid_readdata registered to that master's readdata.
- recheck in ARB: clear boot_done and boot_ok next cycle, go to CHK_ID. No grant issued in the recheck cycle. Any read accepted the cycle before still returns its data normally.
- recheck outside ARB: ignored.
- In CHK_*: m0/m1 waitrequest=1; a master must hold read/address until accepted (Avalon rule).
- Ungranted master in ARB: waitrequest=1 while read=1. When read=0, waitrequest value is don't-care and is driven 0.
- Writes unsupported: no write port; the slave is read-only.

## Timing
- Reset values: state=CHK_ID, boot_done=0, boot_ok=0, mismatch_cnt=0, last_grant=m1 (m0 wins first tie), m*_readdatavalid=0, m*_readdata=0, m*_waitrequest=1.
- Boot check: boot_done rises at the end of the 3rd clock after reset deassertion. The first grant is possible in the 4th cycle.
- Read latency: fixed 1 cycle. Accepted at edge N -> readdatavalid=1 with data during cycle N+1 for exactly one cycle.
- Throughput: one accepted read per cycle total. With both masters continuously requesting, grants strictly alternate.
- readdata holds its last value when readdatavalid=0.
- Reset mid-operation: pending responses are discarded (readdatavalid=0 next cycle); mismatch_cnt clears; the sequence restarts.

## Structure
- Package sysid_arbiter_pkg: state enum, ADDR_ID=1'b0, ADDR_TS=1'b1, mismatch counter width constant.
- Sub-module sysid_rr_arb2: 2-way round-robin grant with last_grant register. Inputs: req[1:0], advance. Output: one-hot gnt[1:0].
- The top level holds the FSM, capture registers, compare logic and response registers.

## Test plan
- Reset, slave model returns 0 / 5C00A374 -> boot_done=1 and boot_ok=1 after 3 cycles; mismatch_cnt=0; waitrequest high on both masters until then.
- Slave timestamp 5C00A375 -> boot_ok=0 and mismatch_cnt=1. Pulse recheck 300 times -> mismatch_cnt saturates at FF.
- m0 and m1 both read address 1 continuously for 6 cycles -> grants m0,m1,m0,m1,m0,m1; each readdatavalid one cycle after its accept with 5C00A374.
- m1 alone reads address 0, back-to-back 4 cycles -> 4 accepts and 4 consecutive readdatavalid pulses with data 0; m0 waitrequest unaffected.
- recheck asserted the cycle after an m0 accept -> m0 still receives readdatavalid. Both masters stalled for 3 cycles; boot_done falls then rises.
- Assert reset for one cycle while m0 has a read in flight -> no readdatavalid; all outputs at reset values; boot sequence reruns.
